// File: rtl/pipeline_if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pipeline_if_stage_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_EXC,
        SEL_BRANCH,
        SEL_IRQ,
        SEL_JR,
        SEL_JUMP
    } pc_sel_e;

    // The supervisor bit is never carried into by sequential fetch.
    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pipeline_next_pc.sv
// Combinational next-PC priority mux for the fetch stage, plus bubble/EPC decisions.
module pipeline_next_pc #(
    parameter logic [31:0] IRQ_VEC = pipeline_if_stage_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC = pipeline_if_stage_pkg::EXC_VEC
) (
    input  logic [31:0]                     pc,
    input  logic [31:0]                     if_id_pc_plus4,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            branch_taken,
    input  logic [31:0]                     branch_target,
    input  logic                            jump,
    input  logic [25:0]                     jump_index,
    input  logic                            jr,
    input  logic [31:0]                     jr_target,
    input  logic                            irq,
    input  logic                            illop,
    output logic [31:0]                     next_pc,
    output logic [31:0]                     pc_plus4,
    output pipeline_if_stage_pkg::pc_sel_e  pc_sel,
    output logic                            bubble,
    output logic                            epc_take,
    output logic [31:0]                     epc_value
);
    import pipeline_if_stage_pkg::*;

    logic irq_take;

    assign pc_plus4 = seq_next(pc);

    // Masked in supervisor mode; deferred behind any redirect or stall.
    assign irq_take = irq & ~pc[31] & ~stall & ~branch_taken & ~jump & ~jr & ~illop;

    always_comb begin
        pc_sel    = SEL_SEQ;
        next_pc   = pc_plus4;
        epc_take  = 1'b0;
        epc_value = if_id_pc_plus4;
        if (illop) begin
            pc_sel    = SEL_EXC;
            next_pc   = EXC_VEC;
            epc_take  = 1'b1;
            epc_value = if_id_pc_plus4;
        end else if (branch_taken) begin
            pc_sel  = SEL_BRANCH;
            next_pc = branch_target;
        end else if (irq_take) begin
            pc_sel    = SEL_IRQ;
            next_pc   = IRQ_VEC;
            epc_take  = 1'b1;
            epc_value = pc;
        end else if (jr) begin
            pc_sel  = SEL_JR;
            next_pc = jr_target;
        end else if (jump) begin
            pc_sel  = SEL_JUMP;
            next_pc = {if_id_pc_plus4[31:28], jump_index, 2'b00};
        end else if (stall) begin
            pc_sel  = SEL_HOLD;
            next_pc = pc;
        end
    end

    assign bubble = flush | ((pc_sel != SEL_SEQ) & (pc_sel != SEL_HOLD));

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and EPC capture.
module pipeline_if_stage #(
    parameter logic [31:0] RESET_VEC = pipeline_if_stage_pkg::RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = pipeline_if_stage_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = pipeline_if_stage_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        illop,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [6:0]  pc_82,
    output logic        imem_nop,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] epc,
    output logic        epc_we
);
    import pipeline_if_stage_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        epc_we_q, epc_we_d;

    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    pc_sel_e     pc_sel;
    logic        bubble;
    logic        epc_take;
    logic [31:0] epc_value;

    pipeline_next_pc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc (
        .pc             (pc_q),
        .if_id_pc_plus4 (if_id_pc_plus4_q),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .irq            (irq),
        .illop          (illop),
        .next_pc        (next_pc),
        .pc_plus4       (pc_plus4),
        .pc_sel         (pc_sel),
        .bubble         (bubble),
        .epc_take       (epc_take),
        .epc_value      (epc_value)
    );

    always_comb begin
        pc_d             = next_pc;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        epc_d            = epc_q;
        epc_we_d         = epc_take;
        // Flush beats a plain stall for IF/ID even though the PC holds.
        if (bubble) begin
            if_id_instr_d    = NOP_INSTR;
            if_id_valid_d    = 1'b0;
            if_id_pc_plus4_d = pc_plus4;
        end else if (pc_sel != SEL_HOLD) begin
            if_id_instr_d    = instr;
            if_id_valid_d    = 1'b1;
            if_id_pc_plus4_d = pc_plus4;
        end
        if (epc_take) begin
            epc_d = epc_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_VEC;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_plus4_q <= RESET_VEC;
            if_id_valid_q    <= 1'b0;
            epc_q            <= 32'h0;
            epc_we_q         <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            epc_q            <= epc_d;
            epc_we_q         <= epc_we_d;
        end
    end

    assign pc             = pc_q;
    assign pc_82          = pc_q[8:2];
    assign imem_nop       = bubble;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign epc            = epc_q;
    assign epc_we         = epc_we_q;

endmodule

// File: doc/pipeline_if_stage.md
Name: pipeline_if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and next-PC selection: sequential, branch, jump, jr, interrupt, exception, reset vector.
- Drives the word address and nop kill into the instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- PC[31] is the supervisor bit; sequential increment never alters it.

Parameters:
- RESET_VEC, 32'h8000_0000, PC value after reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry.
- EXC_VEC, 32'h8000_0008, illegal-instruction entry.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- flush  in  1  kill the instruction in IF/ID; PC advances normally.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  32  EX-stage branch address.
- jump  in  1  ID-stage j/jal.
- jump_index  in  26  instr[25:0] of that jump.
- jr  in  1  ID-stage jr/jalr.
- jr_target  in  32  forwarded rs value.
- irq  in  1  level interrupt request from timer/peripherals.
- illop  in  1  ID-stage undefined opcode.
- instr  in  32  instruction-memory data.
- pc  out  32  current fetch PC.
- pc_82  out  7  pc[8:2], instruction-memory word address.
- imem_nop  out  1  forces instruction memory output to 0.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc_plus4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- epc  out  32  return address for $26/xp.
- epc_we  out  1  one-cycle write strobe for epc.

Behaviour:
- Sequential increment: pc_plus4 = {pc[31], pc[30:0]+4}; bit 31 is never carried into.
- Jump target: {pc_plus4_id[31:28], jump_index, 2'b00}, with pc_plus4_id = if_id_pc_plus4.
- Reset, all outputs:
  - pc = RESET_VEC.
  - if_id_instr = 0.
  - if_id_pc_plus4 = RESET_VEC.
  - if_id_valid = 0.
  - epc = 0.
  - epc_we = 0.
  - Reset mid-operation discards all pending redirects.
- irq_take = irq & ~pc[31] & ~stall & ~branch_taken & ~jump & ~jr & ~illop. Interrupts are masked in supervisor mode and deferred one cycle behind any redirect.
- Next-PC priority, highest first; one choice per clock edge:
  1. illop: pc <= EXC_VEC; epc <= if_id_pc_plus4; epc_we <= 1.
  2. branch_taken: pc <= branch_target. Overrides stall and jump/jr (older instruction).
  3. irq_take: pc <= IRQ_VEC; epc <= pc; epc_we <= 1.
  4. jr: pc <= jr_target. jr may clear pc[31]; this is the exception return.
  5. jump: pc <= jump target.
  6. stall: pc holds.
  7. Otherwise: pc <= pc_plus4.
- IF/ID update on the same edge:
  - Cases 1, 2 or 3, or flush: bubble. if_id_instr <= 0, if_id_valid <= 0, if_id_pc_plus4 <= pc_plus4.
  - Cases 4 or 5: bubble (delay slot not executed).
  - stall alone: hold all IF/ID fields.
  - Otherwise: if_id_instr <= instr, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
- imem_nop is combinational: high whenever this edge produces a bubble (cases 1–5 or flush). Low during stall alone.
- epc_we is high for exactly one cycle after the taking edge; epc holds its value otherwise.
- Latency: instruction at PC p appears in if_id_instr one edge after pc == p, unless killed.
- Stall plus flush in the same cycle: flush wins for IF/ID; PC holds.
- Simultaneous illop and branch_taken: illop wins (defined priority). The ID-stage decoder guarantees these are mutually exclusive in practice.

Decomposition:
- Shared package: RESET_VEC, IRQ_VEC, EXC_VEC, and the NOP instruction constant (32'h0).
- One natural sub-module, pipeline_next_pc: a pure combinational priority mux and adder.
- Registers stay in pipeline_if_stage.

Test Plan:
- Reset, then 3 free-running cycles: pc = 8000_0000 → 8000_0004 → 8000_0008; pc_82 = 0,1,2; if_id_valid rises after the first edge.
- stall held 2 cycles at pc = 0000_0010: pc and if_id_instr frozen; imem_nop = 0; resumes at 0000_0014.
- branch_taken with target 0000_00AC while stall = 1: next pc = 0000_00AC; IF/ID bubble (instr 0, valid 0).
- jump_index = 0x2B with if_id_pc_plus4 = 0000_00B0: pc = 0000_00AC; one bubble.
- irq at pc = 0000_00D4: pc = 8000_0004, epc = 0000_00D4, epc_we pulse. irq held while pc[31] = 1: no retake. jr_target 0000_00D4: resumes at 0000_00D4.
- illop with if_id_pc_plus4 = 0000_0100 and simultaneous irq: pc = 8000_0008, epc = 0000_0100; irq deferred until pc[31] returns to 0.
